lut_neuron_layer_rt: RTL

//  Runtime-programmable successor to the fixed per-neuron truth-table ROM modules.

---
 rtl/lut_neuron_layer_rt_pkg.sv | 23 ++
 rtl/lut_neuron_layer_rt_if.sv | 36 +++
 rtl/lut_neuron_layer_rt_ram.sv | 24 ++
 rtl/lut_neuron_layer_rt.sv | 110 +++++++++++
 4 files changed

// File: rtl/lut_neuron_layer_rt_pkg.sv
// Shared types, default widths and width helpers for the runtime-programmable LUT neuron layer.
package lut_layer_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int DEF_NUM_NEURONS = 4;
  localparam int DEF_FAN_IN      = 4;
  localparam int DEF_IN_BW       = 2;
  localparam int DEF_OUT_BW      = 2;

  function automatic int addr_w(input int fan_in, input int in_bw);
    return fan_in * in_bw;
  endfunction

  // Neuron-select width never drops below one bit, even for a single-neuron layer.
  function automatic int nid_w(input int num_neurons);
    return (num_neurons > 2) ? $clog2(num_neurons) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_layer_rt_if.sv
// Lookup datapath, config port and status bundle of the LUT neuron layer.
interface lut_layer_if
  import lut_layer_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int ADDR_W      = addr_w(DEF_FAN_IN, DEF_IN_BW),
  parameter int OUT_BW      = DEF_OUT_BW,
  parameter int NID_W       = nid_w(DEF_NUM_NEURONS)
);
  // Handshake: a transfer happens on a rising clk edge where valid && ready; the
  // source holds valid and payload stable until then, ready may change freely.
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_NEURONS*ADDR_W-1:0] in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_NEURONS*OUT_BW-1:0] out_data;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [NID_W-1:0]              cfg_neuron;
  logic [ADDR_W-1:0]             cfg_addr;
  logic [OUT_BW-1:0]             cfg_data;
  logic                          cfg_err;
  logic                          busy;

  modport master (
    output in_valid, in_data, out_ready, cfg_valid, cfg_neuron, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ready, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_valid, cfg_neuron, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ready, cfg_err, busy
  );

endinterface

// File: rtl/lut_neuron_layer_rt_ram.sv
// One neuron truth table: synchronous write, asynchronous read, no reset on the storage.
module lut_neuron_ram #(
  parameter int ADDR_W = 8,
  parameter int OUT_BW = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [OUT_BW-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [OUT_BW-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [OUT_BW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A read and write of the same entry in one cycle returns the pre-write contents.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_neuron_layer_rt.sv
// Runtime-programmable LUT neuron layer: post-reset clear sweep, config writes and a
// 2-stage valid/ready lookup pipeline whose table read happens on the S1->S2 transfer.
module lut_neuron_layer_rt
  import lut_layer_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int FAN_IN      = DEF_FAN_IN,
  parameter int IN_BW       = DEF_IN_BW,
  parameter int OUT_BW      = DEF_OUT_BW,
  parameter int ADDR_W      = addr_w(FAN_IN, IN_BW),
  parameter int NID_W       = nid_w(NUM_NEURONS)
) (
  input  logic         clk,
  input  logic         rst,
  lut_layer_if.slave   bus,
  output state_t       dbg_state_o
);

  state_t                        state_q;
  logic [ADDR_W-1:0]             clr_cnt_q;
  logic                          s1_valid_q;
  logic [NUM_NEURONS*ADDR_W-1:0] s1_addr_q;
  logic                          s2_valid_q;
  logic [NUM_NEURONS*OUT_BW-1:0] s2_data_q;
  logic                          cfg_err_q;

  logic                          clearing;
  logic                          s1_adv;
  logic                          s2_adv;
  logic                          in_fire;
  logic                          cfg_fire;
  logic                          cfg_in_range;
  logic [NUM_NEURONS*OUT_BW-1:0] rd_data;

  assign clearing     = (state_q == ST_CLEAR);
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign cfg_fire     = bus.cfg_valid && bus.cfg_ready;
  assign cfg_in_range = 32'(bus.cfg_neuron) < NUM_NEURONS;

  // During the sweep every table is written with zero at the sweep address.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [OUT_BW-1:0] wdata;

    assign we    = clearing || (cfg_fire && cfg_in_range && (bus.cfg_neuron == NID_W'(n)));
    assign waddr = clearing ? clr_cnt_q : bus.cfg_addr;
    assign wdata = clearing ? '0 : bus.cfg_data;

    lut_neuron_ram #(
      .ADDR_W (ADDR_W),
      .OUT_BW (OUT_BW)
    ) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (s1_addr_q[n*ADDR_W +: ADDR_W]),
      .rdata_o (rd_data[n*OUT_BW +: OUT_BW])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) state_q <= ST_RUN;
        end
        ST_RUN:   state_q <= ST_RUN;
        default:  state_q <= ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_fire;
        if (in_fire) s1_addr_q <= bus.in_data;
      end
      // A vector stalled in S1 picks up any writes that land before it moves on.
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= rd_data;
      end
      cfg_err_q <= cfg_fire && !cfg_in_range;
    end
  end

  assign bus.in_ready  = (state_q == ST_RUN) && s1_adv;
  assign bus.cfg_ready = (state_q == ST_RUN);
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.busy      = clearing;
  assign dbg_state_o   = state_q;

endmodule
